buzz_sequencer: RTL and testbench

Melody sequencer that drives the buzzer PWM generator. On a start pulse it walks a selected song in an internal note ROM and, for each entry, presents the buzzer's half-period count on `frequency` for the programmed number of beats. Between notes it inserts a silent articulation gap. It pulses `modechange` at every tone boundary so the buzzer restarts its phase cleanly. It sits between the user-mode FSM (start/stop/pause/select) and the buzzer instance.

---
 rtl/buzz_sequencer_pkg.sv | 92 +++++++++
 rtl/buzz_sequencer_if.sv | 24 ++
 rtl/buzz_sequencer_song_rom.sv | 24 ++
 rtl/buzz_sequencer.sv | 166 ++++++++++++++++
 tb/tb_buzz_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/buzz_sequencer_pkg.sv
// Shared definitions for the melody sequencer: note codes, FSM states,
// the half-period lookup and the song ROM contents.
package buzz_pkg;

  localparam int SONG_LEN  = 32;
  localparam int NUM_SONGS = 4;
  localparam int ROM_DEPTH = NUM_SONGS * SONG_LEN;
  localparam int ROM_AW    = 7;

  // Note codes are chromatic: code = semitones above C4, plus one.
  localparam logic [4:0] REST     = 5'd0;
  localparam logic [4:0] C4       = 5'd1;
  localparam logic [4:0] CS4      = 5'd2;
  localparam logic [4:0] D4       = 5'd3;
  localparam logic [4:0] DS4      = 5'd4;
  localparam logic [4:0] E4       = 5'd5;
  localparam logic [4:0] F4       = 5'd6;
  localparam logic [4:0] FS4      = 5'd7;
  localparam logic [4:0] G4       = 5'd8;
  localparam logic [4:0] GS4      = 5'd9;
  localparam logic [4:0] A4       = 5'd10;
  localparam logic [4:0] AS4      = 5'd11;
  localparam logic [4:0] B4       = 5'd12;
  localparam logic [4:0] C5       = 5'd13;
  localparam logic [4:0] CS5      = 5'd14;
  localparam logic [4:0] D5       = 5'd15;
  localparam logic [4:0] DS5      = 5'd16;
  localparam logic [4:0] E5       = 5'd17;
  localparam logic [4:0] F5       = 5'd18;
  localparam logic [4:0] FS5      = 5'd19;
  localparam logic [4:0] G5       = 5'd20;
  localparam logic [4:0] GS5      = 5'd21;
  localparam logic [4:0] END_MARK = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_t;

  // Buzzer half-period count at 100 MHz: round(1e8 / (2 f)) - 1; 0 = silent.
  function automatic logic [31:0] half_period(input logic [4:0] code);
    logic [31:0] hp;
    hp = 32'd0;
    case (code)
      C4:  hp = 32'd191112;
      CS4: hp = 32'd180385;
      D4:  hp = 32'd170261;
      DS4: hp = 32'd160705;
      E4:  hp = 32'd151685;
      F4:  hp = 32'd143172;
      FS4: hp = 32'd135136;
      G4:  hp = 32'd127552;
      GS4: hp = 32'd120393;
      A4:  hp = 32'd113635;
      AS4: hp = 32'd107257;
      B4:  hp = 32'd101237;
      C5:  hp = 32'd95555;
      CS5: hp = 32'd90192;
      D5:  hp = 32'd85130;
      DS5: hp = 32'd80352;
      E5:  hp = 32'd75842;
      F5:  hp = 32'd71585;
      FS5: hp = 32'd67568;
      G5:  hp = 32'd63775;
      GS5: hp = 32'd60196;
      default: hp = 32'd0;
    endcase
    return hp;
  endfunction

  // Song table, entry = {note, beats-1}. Unused slots hold the end marker.
  function automatic logic [7:0] rom_entry(input logic [ROM_AW-1:0] addr);
    logic [7:0] e;
    e = {END_MARK, 3'd0};
    case (addr)
      7'd0:  e = {A4, 3'd1};
      7'd32: e = {A4, 3'd0};
      7'd33: e = {REST, 3'd0};
      7'd34: e = {A4, 3'd0};
      7'd64: e = {C4, 3'd0};
      7'd65: e = {E4, 3'd0};
      7'd96: e = {G4, 3'd1};
      7'd97: e = {C5, 3'd2};
      default: e = {END_MARK, 3'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/buzz_sequencer_if.sv
// Control/status bundle between the user-mode FSM (master) and the
// melody sequencer (slave).
interface buzz_sequencer_if;
  logic        start;
  logic        stop;
  logic        pause;
  logic        loop;
  logic [1:0]  song_sel;
  logic [31:0] frequency;
  logic        modechange;
  logic        busy;
  logic        done;
  logic [4:0]  note_idx;

  modport master (
    output start, stop, pause, loop, song_sel,
    input  frequency, modechange, busy, done, note_idx
  );

  modport slave (
    input  start, stop, pause, loop, song_sel,
    output frequency, modechange, busy, done, note_idx
  );
endinterface

// File: rtl/buzz_sequencer_song_rom.sv
// Song storage: 4 songs x 32 entries, synchronous read, one cycle latency.
module song_rom
  import buzz_pkg::*;
(
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [7:0]        data
);
  logic [7:0] mem [ROM_DEPTH];
  logic [7:0] data_d;
  logic [7:0] data_q;

  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    assign mem[gi] = rom_entry(ROM_AW'(gi));
  end

  // Address decode feeding the read register.
  always_comb data_d = mem[addr];

  // Registered read port.
  always_ff @(posedge clk) data_q <= data_d;

  assign data = data_q;
endmodule

// File: rtl/buzz_sequencer.sv
// Melody sequencer: walks a song in the note ROM and drives the buzzer
// half-period, with articulation gaps, pause hold, loop and stop.
module buzz_sequencer
  import buzz_pkg::*;
#(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input logic             clk,
  input logic             reset,
  buzz_sequencer_if.slave bus
);
  localparam logic [24:0] BEAT_LAST = 25'(BEAT_CYCLES - 1);
  localparam logic [24:0] GAP_LAST  = 25'(GAP_CYCLES - 1);
  localparam logic [5:0]  IDX_END   = 6'(SONG_LEN);

  state_t      state_q, state_d;
  logic [1:0]  song_q, song_d;
  logic [5:0]  idx_q, idx_d;   // one extra bit so SONG_LEN itself is visible
  logic [24:0] cyc_q, cyc_d;
  logic [2:0]  beat_q, beat_d;
  logic [31:0] tone_q, tone_d;
  logic [31:0] freq_q, freq_d;
  logic        hold_q, hold_d; // pause as applied on the previous cycle
  logic        mc_q, mc_d;
  logic        done_q, done_d;

  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [4:0]        rom_note;
  logic [2:0]        rom_dur;

  assign rom_addr = {song_q, idx_q[4:0]};
  assign rom_note = rom_data[7:3];
  assign rom_dur  = rom_data[2:0];

  song_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Next-state, counters and output values. Counters advance only for
  // cycles that were actually sounding/gapping (hold_q low), so a paused
  // note still gets its full beat count of audible cycles.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    beat_d  = beat_q;
    tone_d  = tone_q;
    freq_d  = freq_q;
    hold_d  = hold_q;
    mc_d    = 1'b0;
    done_d  = 1'b0;

    if (state_q != ST_IDLE && bus.stop) begin
      state_d = ST_IDLE;
      freq_d  = 32'd0;
      mc_d    = 1'b1;
      hold_d  = 1'b0;
      cyc_d   = 25'd0;
      beat_d  = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_FETCH;
            song_d  = bus.song_sel;
            idx_d   = 6'd0;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          if (rom_note == END_MARK || idx_q == IDX_END) begin
            if (bus.loop) begin
              idx_d   = 6'd0;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_PLAY;
            tone_d  = half_period(rom_note);
            freq_d  = bus.pause ? 32'd0 : half_period(rom_note);
            hold_d  = bus.pause;
            mc_d    = 1'b1;
            cyc_d   = 25'd0;
            beat_d  = rom_dur;
          end
        end
        ST_PLAY: begin
          hold_d = bus.pause;
          freq_d = bus.pause ? 32'd0 : tone_q;
          mc_d   = (bus.pause != hold_q);
          if (!hold_q) begin
            if (cyc_q == BEAT_LAST) begin
              cyc_d = 25'd0;
              if (beat_q == 3'd0) begin
                state_d = ST_GAP;
                freq_d  = 32'd0;
                mc_d    = 1'b1;
              end else begin
                beat_d = beat_q - 3'd1;
              end
            end else begin
              cyc_d = cyc_q + 25'd1;
            end
          end
        end
        ST_GAP: begin
          hold_d = bus.pause;
          freq_d = 32'd0;
          mc_d   = (bus.pause != hold_q);
          if (!hold_q) begin
            if (cyc_q == GAP_LAST) begin
              cyc_d   = 25'd0;
              state_d = ST_FETCH;
              idx_d   = idx_q + 6'd1;
              hold_d  = 1'b0;
              mc_d    = 1'b0;
            end else begin
              cyc_d = cyc_q + 25'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      song_q  <= 2'd0;
      idx_q   <= 6'd0;
      cyc_q   <= 25'd0;
      beat_q  <= 3'd0;
      tone_q  <= 32'd0;
      freq_q  <= 32'd0;
      hold_q  <= 1'b0;
      mc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      beat_q  <= beat_d;
      tone_q  <= tone_d;
      freq_q  <= freq_d;
      hold_q  <= hold_d;
      mc_q    <= mc_d;
      done_q  <= done_d;
    end
  end

  assign bus.frequency  = freq_q;
  assign bus.modechange = mc_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.note_idx   = idx_q[4:0];
endmodule

// File: tb/tb_buzz_sequencer.sv
// Scoreboarded bench for buzz_sequencer with short beat/gap timing.
`timescale 1ns/1ps
module tb_buzz_sequencer;
  localparam int BEAT = 4;
  localparam int GAP  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  buzz_sequencer_if bus();

  buzz_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One record per clock: expected outputs at this falling edge, then the
  // inputs to drive for the next rising edge.
  typedef struct {
    logic [31:0] freq;
    logic        mc;
    logic        dn;
    logic        bz;
    int          idx;  // -1: note_idx not checked
    logic        st;
    logic        sp;
    logic        p;
    logic        lp;
    int          ss;   // -1: song_sel unchanged
  } rec_t;

  rec_t sb[$];
  int checks = 0;
  int errors = 0;

  // Independent model of the tuning: equal temperament around A4 = code 10.
  function automatic logic [31:0] exp_hp(input int code);
    real f;
    f = 440.0 * (2.0 ** ((code - 10) / 12.0));
    return 32'($rtoi(100_000_000.0 / (2.0 * f) - 1.0 + 0.5));
  endfunction

  task automatic add(input int n, input logic [31:0] f, input logic mc, input logic dn,
                     input logic bz, input int idx, input logic st = 1'b0, input logic sp = 1'b0,
                     input logic p = 1'b0, input logic lp = 1'b0, input int ss = -1);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r.freq = f; r.mc = mc; r.dn = dn; r.bz = bz; r.idx = idx;
      r.st = st; r.sp = sp; r.p = p; r.lp = lp; r.ss = ss;
      sb.push_back(r);
    end
  endtask

  // Capture outputs, pop the expectation, drive the next inputs, advance.
  task automatic pop_cycle(output rec_t r, output logic [34:0] obs, output logic [4:0] oidx);
    r    = sb.pop_front();
    obs  = {bus.frequency, bus.modechange, bus.done, bus.busy};
    oidx = bus.note_idx;
    bus.start = r.st;
    bus.stop  = r.sp;
    bus.pause = r.p;
    bus.loop  = r.lp;
    if (r.ss >= 0) bus.song_sel = 2'(r.ss);
    @(negedge clk);
  endtask

  // Song 0: A4 for two beats, then end. A start while busy is injected and
  // song_sel is changed after the accepted start; neither may matter.
  task automatic push_song0();
    logic [31:0] a;
    a = exp_hp(10);
    add(1, 0, 0, 0, 0, -1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 1, 0);
    add(1, a, 1, 0, 1, 0);
    add(2, a, 0, 0, 1, 0);
    add(1, a, 0, 0, 1, 0, 1);
    add(4, a, 0, 0, 1, 0);
    add(1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0);
    add(2, 0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 0, -1);
    add(1, 0, 0, 0, 0, -1);
  endtask

  task automatic test_reset();
    rec_t r; logic [34:0] obs; logic [4:0] oidx; int n;
    n = 0;
    add(2, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      if (n == 2) reset = 1'b1;
      pop_cycle(r, obs, oidx);
      checks++;
      if (obs !== {r.freq, r.mc, r.dn, r.bz}) begin
        errors++;
        $display("FAIL reset cyc%0d: got freq=%0d mc/done/busy=%b want freq=%0d mc/done/busy=%b",
                 n, obs[34:3], obs[2:0], r.freq, {r.mc, r.dn, r.bz});
      end
      checks++;
      if (oidx !== 5'(r.idx)) begin
        errors++;
        $display("FAIL reset_idx cyc%0d: got %0d want %0d", n, oidx, r.idx);
      end
      n++;
    end
    $display("test reset: %0d cycles compared", n);
  endtask

  task automatic test_single_note();
    rec_t r; logic [34:0] obs; logic [4:0] oidx; int n;
    n = 0;
    push_song0();
    while (sb.size() > 0) begin
      pop_cycle(r, obs, oidx);
      checks++;
      if (obs !== {r.freq, r.mc, r.dn, r.bz}) begin
        errors++;
        $display("FAIL single cyc%0d: got freq=%0d mc/done/busy=%b want freq=%0d mc/done/busy=%b",
                 n, obs[34:3], obs[2:0], r.freq, {r.mc, r.dn, r.bz});
      end
      if (r.idx >= 0) begin
        checks++;
        if (oidx !== 5'(r.idx)) begin
          errors++;
          $display("FAIL single_idx cyc%0d: got %0d want %0d", n, oidx, r.idx);
        end
      end
      n++;
    end
    $display("test single_note: %0d cycles compared", n);
  endtask

  task automatic test_rest_repeat();
    rec_t r; logic [34:0] obs; logic [4:0] oidx; int n;
    logic [31:0] f;
    n = 0;
    add(1, 0, 0, 0, 0, -1, 1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      f = (k == 1) ? 32'd0 : exp_hp(10);
      add(2, 0, 0, 0, 1, k);
      add(1, f, 1, 0, 1, k);
      add(3, f, 0, 0, 1, k);
      add(1, 0, 1, 0, 1, k);
      add(1, 0, 0, 0, 1, k);
    end
    add(2, 0, 0, 0, 1, 3);
    add(1, 0, 0, 1, 0, -1);
    add(1, 0, 0, 0, 0, -1);
    while (sb.size() > 0) begin
      pop_cycle(r, obs, oidx);
      checks++;
      if (obs !== {r.freq, r.mc, r.dn, r.bz}) begin
        errors++;
        $display("FAIL rest_repeat cyc%0d: got freq=%0d mc/done/busy=%b want freq=%0d mc/done/busy=%b",
                 n, obs[34:3], obs[2:0], r.freq, {r.mc, r.dn, r.bz});
      end
      if (r.idx >= 0) begin
        checks++;
        if (oidx !== 5'(r.idx)) begin
          errors++;
          $display("FAIL rest_repeat_idx cyc%0d: got %0d want %0d", n, oidx, r.idx);
        end
      end
      n++;
    end
    $display("test rest_repeat: %0d cycles compared", n);
  endtask

  // Pause for 10 edges after two audible cycles; two cycles must remain.
  // A stop during the following gap ends the song without done.
  task automatic test_pause();
    rec_t r; logic [34:0] obs; logic [4:0] oidx; int n;
    logic [31:0] a;
    a = exp_hp(10);
    n = 0;
    add(1, 0, 0, 0, 0, -1, 1, 0, 0, 0, 1);
    add(2, 0, 0, 0, 1, 0);
    add(1, a, 1, 0, 1, 0);
    add(1, a, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 1, 0, 0, 0, 1);
    add(8, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0);
    add(1, a, 1, 0, 1, 0);
    add(1, a, 0, 0, 1, 0);
    add(1, 0, 1, 0, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0, -1);
    add(2, 0, 0, 0, 0, -1);
    while (sb.size() > 0) begin
      pop_cycle(r, obs, oidx);
      checks++;
      if (obs !== {r.freq, r.mc, r.dn, r.bz}) begin
        errors++;
        $display("FAIL pause cyc%0d: got freq=%0d mc/done/busy=%b want freq=%0d mc/done/busy=%b",
                 n, obs[34:3], obs[2:0], r.freq, {r.mc, r.dn, r.bz});
      end
      if (r.idx >= 0) begin
        checks++;
        if (oidx !== 5'(r.idx)) begin
          errors++;
          $display("FAIL pause_idx cyc%0d: got %0d want %0d", n, oidx, r.idx);
        end
      end
      n++;
    end
    $display("test pause: %0d cycles compared", n);
  endtask

  // stop+start together mid-note, then a stop while idle.
  task automatic test_stop_start();
    rec_t r; logic [34:0] obs; logic [4:0] oidx; int n;
    logic [31:0] a;
    a = exp_hp(10);
    n = 0;
    add(1, 0, 0, 0, 0, -1, 1, 0, 0, 0, 0);
    add(2, 0, 0, 0, 1, 0);
    add(1, a, 1, 0, 1, 0);
    add(1, a, 0, 0, 1, 0);
    add(1, a, 0, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 0, -1, 0, 1);
    add(3, 0, 0, 0, 0, -1);
    while (sb.size() > 0) begin
      pop_cycle(r, obs, oidx);
      checks++;
      if (obs !== {r.freq, r.mc, r.dn, r.bz}) begin
        errors++;
        $display("FAIL stop_start cyc%0d: got freq=%0d mc/done/busy=%b want freq=%0d mc/done/busy=%b",
                 n, obs[34:3], obs[2:0], r.freq, {r.mc, r.dn, r.bz});
      end
      n++;
    end
    $display("test stop_start: %0d cycles compared", n);
  endtask

  // Song 2 (C4, E4) looped twice, loop cleared during the third pass.
  task automatic test_loop();
    rec_t r; logic [34:0] obs; logic [4:0] oidx; int n;
    logic [31:0] f;
    logic lp;
    n = 0;
    add(1, 0, 0, 0, 0, -1, 1, 0, 0, 1, 2);
    for (int pass = 0; pass < 3; pass++) begin
      lp = (pass < 2);
      for (int k = 0; k < 2; k++) begin
        f = (k == 0) ? exp_hp(1) : exp_hp(5);
        add(2, 0, 0, 0, 1, k, 0, 0, 0, lp);
        add(1, f, 1, 0, 1, k, 0, 0, 0, lp);
        add(3, f, 0, 0, 1, k, 0, 0, 0, lp);
        add(1, 0, 1, 0, 1, k, 0, 0, 0, lp);
        add(1, 0, 0, 0, 1, k, 0, 0, 0, lp);
      end
      add(2, 0, 0, 0, 1, 2, 0, 0, 0, lp);
    end
    add(1, 0, 0, 1, 0, -1);
    add(1, 0, 0, 0, 0, -1);
    while (sb.size() > 0) begin
      pop_cycle(r, obs, oidx);
      checks++;
      if (obs !== {r.freq, r.mc, r.dn, r.bz}) begin
        errors++;
        $display("FAIL loop cyc%0d: got freq=%0d mc/done/busy=%b want freq=%0d mc/done/busy=%b",
                 n, obs[34:3], obs[2:0], r.freq, {r.mc, r.dn, r.bz});
      end
      if (r.idx >= 0) begin
        checks++;
        if (oidx !== 5'(r.idx)) begin
          errors++;
          $display("FAIL loop_idx cyc%0d: got %0d want %0d", n, oidx, r.idx);
        end
      end
      n++;
    end
    $display("test loop: %0d cycles compared", n);
  endtask

  // Reset dropped between edges mid-note, then a full replay of song 0.
  task automatic test_async_reset();
    rec_t r; logic [34:0] obs; logic [4:0] oidx; int n;
    logic [31:0] a;
    a = exp_hp(10);
    n = 0;
    add(1, 0, 0, 0, 0, -1, 1, 0, 0, 0, 0);
    add(2, 0, 0, 0, 1, 0);
    add(1, a, 1, 0, 1, 0);
    add(1, a, 0, 0, 1, 0);
    while (sb.size() > 0) begin
      pop_cycle(r, obs, oidx);
      checks++;
      if (obs !== {r.freq, r.mc, r.dn, r.bz}) begin
        errors++;
        $display("FAIL async_pre cyc%0d: got freq=%0d mc/done/busy=%b want freq=%0d mc/done/busy=%b",
                 n, obs[34:3], obs[2:0], r.freq, {r.mc, r.dn, r.bz});
      end
      n++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.frequency, bus.modechange, bus.done, bus.busy, bus.note_idx} !== 40'd0) begin
      errors++;
      $display("FAIL async_reset: got freq=%0d mc/done/busy=%b idx=%0d want all zero",
               bus.frequency, {bus.modechange, bus.done, bus.busy}, bus.note_idx);
    end
    @(negedge clk);
    reset = 1'b1;
    push_song0();
    while (sb.size() > 0) begin
      pop_cycle(r, obs, oidx);
      checks++;
      if (obs !== {r.freq, r.mc, r.dn, r.bz}) begin
        errors++;
        $display("FAIL async_replay cyc%0d: got freq=%0d mc/done/busy=%b want freq=%0d mc/done/busy=%b",
                 n, obs[34:3], obs[2:0], r.freq, {r.mc, r.dn, r.bz});
      end
      if (r.idx >= 0) begin
        checks++;
        if (oidx !== 5'(r.idx)) begin
          errors++;
          $display("FAIL async_replay_idx cyc%0d: got %0d want %0d", n, oidx, r.idx);
        end
      end
      n++;
    end
    $display("test async_reset: %0d cycles compared", n);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.loop     = 1'b0;
    bus.song_sel = 2'd0;
    #2 reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_note();
    test_rest_repeat();
    test_pause();
    test_stop_start();
    test_loop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end
endmodule
